// File: rtl/axi_lite_rr_arbiter.sv
// Two-master, one-slave AXI4-Lite arbiter: round-robin grant, one outstanding
// transaction, grant held from the address phase until the response handshake.
module axi_lite_rr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,

    // master 0 (IFU)
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [2:0]          m0_arsize,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [2:0]          m0_awsize,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    output logic [1:0]          m0_bresp,
    output logic                m0_bvalid,
    input  logic                m0_bready,

    // master 1 (LSU)
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [2:0]          m1_arsize,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [2:0]          m1_awsize,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,

    // slave port
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [2:0]          s_arsize,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [2:0]          s_awsize,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,

    output logic [1:0]          grant
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t state_reg, state_next;
    logic   owner_reg, owner_next;
    logic   last_reg, last_next;
    logic   aw_done_reg, aw_done_next;
    logic   w_done_reg, w_done_next;

    // Per-master request side packed by index so the owner mux is a simple select.
    logic [1:0][ADDR_W-1:0] in_araddr, in_awaddr;
    logic [1:0][2:0]        in_arsize, in_awsize;
    logic [1:0][DATA_W-1:0] in_wdata;
    logic [1:0][STRB_W-1:0] in_wstrb;
    logic [1:0]             in_arvalid, in_awvalid, in_wvalid, in_rready, in_bready;

    assign in_araddr  = {m1_araddr,  m0_araddr};
    assign in_arsize  = {m1_arsize,  m0_arsize};
    assign in_arvalid = {m1_arvalid, m0_arvalid};
    assign in_rready  = {m1_rready,  m0_rready};
    assign in_awaddr  = {m1_awaddr,  m0_awaddr};
    assign in_awsize  = {m1_awsize,  m0_awsize};
    assign in_awvalid = {m1_awvalid, m0_awvalid};
    assign in_wdata   = {m1_wdata,   m0_wdata};
    assign in_wstrb   = {m1_wstrb,   m0_wstrb};
    assign in_wvalid  = {m1_wvalid,  m0_wvalid};
    assign in_bready  = {m1_bready,  m0_bready};

    logic in_rd_addr, in_rd_data, in_wr, in_wr_resp;
    assign in_rd_addr = (state_reg == RD_ADDR);
    assign in_rd_data = (state_reg == RD_DATA);
    assign in_wr      = (state_reg == WR);
    assign in_wr_resp = (state_reg == WR_RESP);

    logic [1:0] req;
    logic       pick;
    assign req  = in_arvalid | in_awvalid;
    // On a tie the master that was not served last wins; otherwise the lone requester.
    assign pick = (req[0] & req[1]) ? ~last_reg : req[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            owner_reg   <= 1'b0;
            last_reg    <= 1'b1;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            last_reg    <= last_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        last_next    = last_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        case (state_reg)
            IDLE: begin
                if (req != 2'b00) begin
                    owner_next = pick;
                    state_next = in_arvalid[pick] ? RD_ADDR : WR;
                end
            end
            RD_ADDR: begin
                if (s_arvalid && s_arready) state_next = RD_DATA;
            end
            RD_DATA: begin
                if (s_rvalid && s_rready) begin
                    state_next = IDLE;
                    last_next  = owner_reg;
                end
            end
            WR: begin
                if ((aw_done_reg || (s_awvalid && s_awready)) &&
                    (w_done_reg  || (s_wvalid  && s_wready))) begin
                    state_next   = WR_RESP;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end else begin
                    if (s_awvalid && s_awready) aw_done_next = 1'b1;
                    if (s_wvalid && s_wready)   w_done_next  = 1'b1;
                end
            end
            WR_RESP: begin
                if (s_bvalid && s_bready) begin
                    state_next = IDLE;
                    last_next  = owner_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slave side: only the channels of the current phase carry anything.
    always_comb begin
        s_araddr  = '0;
        s_arsize  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = '0;
        s_awsize  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        if (in_rd_addr) begin
            s_araddr  = in_araddr[owner_reg];
            s_arsize  = in_arsize[owner_reg];
            s_arvalid = in_arvalid[owner_reg];
        end
        if (in_rd_data) s_rready = in_rready[owner_reg];
        if (in_wr) begin
            s_awaddr  = in_awaddr[owner_reg];
            s_awsize  = in_awsize[owner_reg];
            s_awvalid = in_awvalid[owner_reg] & ~aw_done_reg;
            s_wdata   = in_wdata[owner_reg];
            s_wstrb   = in_wstrb[owner_reg];
            s_wvalid  = in_wvalid[owner_reg] & ~w_done_reg;
        end
        if (in_wr_resp) s_bready = in_bready[owner_reg];
    end

    // Master side: each master sees the slave only while it owns the port.
    logic [1:0]             out_arready, out_rvalid, out_awready, out_wready, out_bvalid;
    logic [1:0][DATA_W-1:0] out_rdata;
    logic [1:0][1:0]        out_rresp, out_bresp;
    logic [1:0]             mine;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign mine[gi]        = (state_reg != IDLE) && (owner_reg == 1'(gi));
            assign out_arready[gi] = mine[gi] & in_rd_addr & s_arready;
            assign out_rvalid[gi]  = mine[gi] & in_rd_data & s_rvalid;
            assign out_rdata[gi]   = (mine[gi] & in_rd_data) ? s_rdata : '0;
            assign out_rresp[gi]   = (mine[gi] & in_rd_data) ? s_rresp : 2'b00;
            assign out_awready[gi] = mine[gi] & in_wr & ~aw_done_reg & s_awready;
            assign out_wready[gi]  = mine[gi] & in_wr & ~w_done_reg & s_wready;
            assign out_bvalid[gi]  = mine[gi] & in_wr_resp & s_bvalid;
            assign out_bresp[gi]   = (mine[gi] & in_wr_resp) ? s_bresp : 2'b00;
        end
    endgenerate

    assign grant = mine;

    assign m0_arready = out_arready[0];
    assign m0_rvalid  = out_rvalid[0];
    assign m0_rdata   = out_rdata[0];
    assign m0_rresp   = out_rresp[0];
    assign m0_awready = out_awready[0];
    assign m0_wready  = out_wready[0];
    assign m0_bvalid  = out_bvalid[0];
    assign m0_bresp   = out_bresp[0];

    assign m1_arready = out_arready[1];
    assign m1_rvalid  = out_rvalid[1];
    assign m1_rdata   = out_rdata[1];
    assign m1_rresp   = out_rresp[1];
    assign m1_awready = out_awready[1];
    assign m1_wready  = out_wready[1];
    assign m1_bvalid  = out_bvalid[1];
    assign m1_bresp   = out_bresp[1];

endmodule

// File: doc/axi_lite_rr_arbiter.md
Name: axi_lite_rr_arbiter

Overview:
- Two-master, one-slave AXI4-Lite arbiter with round-robin fairness. Both masters may issue reads and writes.
- It replaces the fixed-priority, read-only sharing of the SoC bus port. Master 0 is IFU and master 1 is LSU; the slave side connects to the address decoder/xbar.
- One transaction is outstanding at a time. A grant is held from the address phase until the response handshake completes.

Parameters:
ADDR_W, 32, address width of ar/aw channels
DATA_W, 32, data width of r/w channels (wstrb width is DATA_W/8)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
m{0,1}_araddr/_arsize/_arvalid  in  ADDR_W/3/1  read-address request per master
m{0,1}_arready  out  1  read-address accept per master
m{0,1}_rdata/_rresp/_rvalid  out  DATA_W/2/1  read data per master
m{0,1}_rready  in  1  read data accept per master
m{0,1}_awaddr/_awsize/_awvalid  in  ADDR_W/3/1  write-address request per master
m{0,1}_awready  out  1  write-address accept per master
m{0,1}_wdata/_wstrb/_wvalid  in  DATA_W/DATA_W/8/1  write data per master
m{0,1}_wready  out  1  write data accept per master
m{0,1}_bresp/_bvalid  out  2/1  write response per master
m{0,1}_bready  in  1  write response accept per master
s_araddr/_arsize/_arvalid  out  ADDR_W/3/1  slave read address
s_arready  in  1  slave read-address accept
s_rdata/_rresp/_rvalid  in  DATA_W/2/1  slave read data
s_rready  out  1  slave read data accept
s_awaddr/_awsize/_awvalid, s_wdata/_wstrb/_wvalid, s_bready  out  -  slave write channels, same widths as master side
s_awready/_wready/_bresp/_bvalid  in  -  slave write handshakes and response
grant  out  2  one-hot owner of the slave port (00 when idle)

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP. Registers:
  - owner (1 bit)
  - last (1 bit): master served most recently
  - aw_done, w_done
- Reset (async, any state including mid-transaction):
  - state=IDLE, grant=00, last=1 (master 0 wins the first tie), aw_done=w_done=0.
  - All s_* valid/ready outputs and all m*_ ready/valid outputs are 0. All data/resp outputs are 0.
  - An in-flight slave transaction is abandoned.
- Request per master i: req_i = m_i_arvalid | m_i_awvalid.
- IDLE arbitration:
  - If exactly one req is set, that master is chosen.
  - If both are set, the master != last is chosen.
  - The decision is registered, so there is 1 cycle arbitration latency. No s_ valid is asserted in the cycle a request first appears.
- Within the chosen master, arvalid takes precedence over awvalid: go to RD_ADDR if arvalid, else WR.
- RD_ADDR:
  - s_ar* = owner's ar*; owner's arready = s_arready.
  - On s_arvalid & s_arready, go to RD_DATA.
- RD_DATA:
  - s_rready = owner's rready; owner's r* = s_r*.
  - On s_rvalid & s_rready: go to IDLE, set last=owner, grant=00.
- WR:
  - aw and w channels are forwarded independently. aw_done/w_done are set on their respective handshakes.
  - After its handshake, a channel's s_ valid is forced to 0.
  - When both channels are done (including the same cycle), go to WR_RESP and clear the flags.
- WR_RESP:
  - s_bready = owner's bready; owner's b* = s_b*.
  - On s_bvalid & s_bready: go to IDLE, set last=owner, grant=00.
- Non-owner master:
  - All its ready/valid outputs are 0 and its rdata/rresp/bresp are 0.
  - Its requests are held by AXI rule and served at the next IDLE.
- Slave port signals of channels not active in the current state are 0 (valid/ready/data).
- Error responses (rresp/bresp != 0) are passed through unchanged. The arbiter never generates responses.
- Worst-case wait for a requester is one full transaction of the other master, so there is no starvation.
- Back-to-back: after the response handshake, the next grant is asserted one cycle later (the IDLE cycle).
- All outputs are combinational from the registered state plus pass-through inputs. There is no combinational path from any m_valid to any s_valid in IDLE.

Test Plan:
- M0 read only: m0_araddr=0x3000_0000 with arvalid at cycle 0 → grant=01 and s_arvalid at cycle 1. Slave returns rdata=0xDEADBEEF, rresp=0 → m0 sees rvalid and data; grant=00 after the handshake; m1 outputs stay 0.
- Simultaneous requests after reset: m0 read and m1 read both at cycle 0 → m0 is served first, then m1. Repeat with m0 and m1 continuously requesting → grants alternate 01,10,01,10.
- M1 write with w before aw: wvalid at cycle 1, awvalid at cycle 3, slave ready immediately → s_wvalid drops after its handshake, WR_RESP is entered after the aw handshake. bresp=2'b10 reaches m1 unchanged.
- M1 asserts arvalid and awvalid together → read completes first. The write starts after IDLE with a grant only if it is still the winner (m0 idle).
- Slave stalls: s_arready=0 for 5 cycles, rvalid delayed by 3 cycles → grant is held constant and m0's arready stays 0 until the slave accepts.
- Reset asserted in RD_DATA mid-transaction → grant=00, all valid/ready outputs drop asynchronously. After deassert, an m1-only request is granted within 1 cycle.
